// File: rtl/aes_inv_cipher_top.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_top -- iterative AES-128 decryption engine.
//
// A key and a ciphertext block are captured on an `ld` strobe while idle.
// The full round-key file rk[0..10] is expanded on-chip (one key-schedule
// step per clock). The last step also performs the initial AddRoundKey.
// Ten inverse rounds follow, one per clock, and the plaintext is presented
// with a one-cycle `done` pulse, 20 edges after the `ld` edge.
//
// Ports:
//   clk       in   1    clock, rising edge
//   rst       in   1    synchronous active-high reset
//   ld        in   1    start strobe (honoured only while idle)
//   key       in   128  cipher key, [127:120] is byte 0
//   text_in   in   128  ciphertext, [127:120] is byte 0, column-major state
//   text_out  out  128  plaintext, held until the next completed block
//   done      out  1    one-cycle pulse, text_out valid
//
// Also contains the S-box leaf modules aes_sbox / aes_inv_sbox. They are
// built from GF(2^8) inversion plus the affine map, not from tables.
// ---------------------------------------------------------------------------

package aes_gf_pkg;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (gives 0 for 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a3, a7, a15, a31, a63, a127;
        a3   = gf_mul(gf_mul(a, a), a);
        a7   = gf_mul(gf_mul(a3, a3), a);
        a15  = gf_mul(gf_mul(a7, a7), a);
        a31  = gf_mul(gf_mul(a15, a15), a);
        a63  = gf_mul(gf_mul(a31, a31), a);
        a127 = gf_mul(gf_mul(a63, a63), a);
        return gf_mul(a127, a127);
    endfunction

endpackage

// Forward S-box: affine(inverse(a)).
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);
    import aes_gf_pkg::*;
    logic [7:0] b;
    assign b = gf_inv(a);
    assign d = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse(affine^-1(a)).
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);
    import aes_gf_pkg::*;
    logic [7:0] y;
    assign y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign d = gf_inv(y);
endmodule

module aes_inv_cipher_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic [127:0] text_out,
    output logic         done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_KEXP = 2'd1;
    localparam logic [1:0] ST_DEC  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [3:0]   rc_q, rc_d;
    logic         done_q, done_d;
    logic [127:0] text_out_q, text_out_d;

    logic [127:0] rk_q [0:10];
    logic [127:0] ct_q;
    logic [127:0] s_q;

    logic [127:0] rk_prev, rk_cur, rk_next;
    logic [7:0]   rcon;
    logic [7:0]   sw_in  [4];
    logic [7:0]   sw_out [4];
    logic [127:0] isr_isb;
    logic [127:0] t;

    // ---------------- round-key file read ports ----------------
    always_comb begin
        rk_prev = '0;
        rk_cur  = '0;
        for (int unsigned i = 0; i <= 10; i++) begin
            if (4'(i) == rc_q - 4'd1) rk_prev = rk_q[i];
            if (4'(i) == rc_q)        rk_cur  = rk_q[i];
        end
    end

    always_comb begin
        case (rc_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // ---------------- key schedule step ----------------
    // SubWord(RotWord(w3)): w3 bytes (b12,b13,b14,b15) rotate to (b13,b14,b15,b12).
    assign sw_in[0] = rk_prev[23:16];
    assign sw_in[1] = rk_prev[15:8];
    assign sw_in[2] = rk_prev[7:0];
    assign sw_in[3] = rk_prev[31:24];

    for (genvar g = 0; g < 4; g++) begin : g_ksbox
        aes_sbox u_sbox (.a(sw_in[g]), .d(sw_out[g]));
    end

    always_comb begin
        logic [31:0] w0, w1, w2, w3;
        w0 = rk_prev[127:96] ^ {sw_out[0] ^ rcon, sw_out[1], sw_out[2], sw_out[3]};
        w1 = rk_prev[95:64] ^ w0;
        w2 = rk_prev[63:32] ^ w1;
        w3 = rk_prev[31:0]  ^ w2;
        rk_next = {w0, w1, w2, w3};
    end

    // ---------------- inverse round ----------------
    // InvShiftRows is pure wiring: output byte (row r, col c) takes input
    // byte (row r, col (c - r) mod 4), fed straight into its inverse S-box.
    for (genvar k = 0; k < 16; k++) begin : g_isbox
        localparam int R   = k % 4;
        localparam int C   = k / 4;
        localparam int SRC = ((C - R + 4) % 4) * 4 + R;
        aes_inv_sbox u_isbox (
            .a(s_q[127-8*SRC -: 8]),
            .d(isr_isb[127-8*k -: 8])
        );
    end

    assign t = isr_isb ^ rk_cur;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int unsigned j = 0; j < 4; j++) begin
            a[j]  = col[31-8*j -: 8];
            x2    = xtime(a[j]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[j] = x8 ^ a[j];
            mb[j] = x8 ^ x2 ^ a[j];
            md[j] = x8 ^ x4 ^ a[j];
            me[j] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = inv_mix_col(v[127-32*c -: 32]);
        end
        return r;
    endfunction

    // ---------------- control ----------------
    always_comb begin
        state_d    = state_q;
        rc_d       = rc_q;
        done_d     = 1'b0;
        text_out_d = text_out_q;
        case (state_q)
            ST_IDLE: begin
                if (ld) begin
                    rc_d    = 4'd1;
                    state_d = ST_KEXP;
                end
            end
            ST_KEXP: begin
                if (rc_q == 4'd10) begin
                    rc_d    = 4'd9;
                    state_d = ST_DEC;
                end else begin
                    rc_d = rc_q + 4'd1;
                end
            end
            ST_DEC: begin
                if (rc_q == 4'd0) begin
                    text_out_d = t;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    rc_d = rc_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rc_q       <= '0;
            done_q     <= 1'b0;
            text_out_q <= '0;
        end else begin
            state_q    <= state_d;
            rc_q       <= rc_d;
            done_q     <= done_d;
            text_out_q <= text_out_d;
        end
    end

    // Datapath registers carry no reset; their contents are meaningless
    // until the control path has walked through a full ld sequence.
    always_ff @(posedge clk) begin
        case (state_q)
            ST_IDLE: begin
                if (ld) begin
                    rk_q[0] <= key;
                    ct_q    <= text_in;
                end
            end
            ST_KEXP: begin
                for (int unsigned i = 1; i <= 10; i++) begin
                    if (4'(i) == rc_q) rk_q[i] <= rk_next;
                end
                // Whitening uses the freshly computed rk[10], not the register.
                if (rc_q == 4'd10) s_q <= ct_q ^ rk_next;
            end
            ST_DEC: begin
                if (rc_q != 4'd0) s_q <= inv_mix(t);
            end
            default: ;
        endcase
    end

    assign text_out = text_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher_top -- self-checking bench for aes_inv_cipher_top.
//
// Holds a byte-level AES-128 reference (encrypt and decrypt) whose S-boxes
// are built at start-up by brute-force GF(2^8) inversion. A cycle model
// predicts done/text_out from ld/rst and is compared with the DUT on every
// falling edge. Directed vectors add latency and literal plaintext checks.
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher_top;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld;
    logic [127:0] key;
    logic [127:0] text_in;
    logic [127:0] text_out;
    logic         done;

    always #5 clk = ~clk;

    aes_inv_cipher_top dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .key      (key),
        .text_in  (text_in),
        .text_out (text_out),
        .done     (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sboxes();
        logic [7:0] inv, b, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                     ^ inv[(i+7)%8] ^ c[i];
            sb[x]  = b;
            isb[b] = 8'(x);
        end
    endtask

    function automatic logic [7:0] gb(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [4];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int n = 1; n <= r; n++) begin
            tmp  = {w[3][23:0], w[3][31:24]};
            tmp  = {sb[tmp[31:24]] ^ rc, sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
            w[0] = w[0] ^ tmp;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc   = gmul(rc, 8'h02);
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isb[gb(v, i)] : sb[gb(v, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        int src_c;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src_c = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = gb(v, 4*src_c + r);
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int m = 0; m < 4; m++)
                    acc ^= gmul(coef[(m - j + 4) % 4], gb(v, 4*c + m));
                o[127-8*(4*c+j) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] c);
        logic [127:0] v;
        v = c ^ round_key(k, 10);
        for (int r = 9; r >= 0; r--) begin
            v = shift_rows(v, 1'b1);
            v = sub_bytes(v, 1'b1);
            v = v ^ round_key(k, r);
            if (r != 0) v = mix_cols(v, 1'b1);
        end
        return v;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] v;
        v = p ^ round_key(k, 0);
        for (int r = 1; r <= 10; r++) begin
            v = sub_bytes(v, 1'b0);
            v = shift_rows(v, 1'b0);
            if (r != 10) v = mix_cols(v, 1'b0);
            v = v ^ round_key(k, r);
        end
        return v;
    endfunction

    // ---------------- cycle model ----------------
    int           m_cnt  = 0;
    logic         m_done = 1'b0;
    logic [127:0] m_out  = '0;
    logic [127:0] m_res  = '0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_cnt <= 0;
            m_out <= '0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_out  <= m_res;
            end
        end else if (ld) begin
            m_cnt <= 20;
            m_res <= ref_dec(key, text_in);
        end
    end

    bit checking = 1'b0;

    always @(negedge clk) begin
        if (checking) begin
            chk("done_vs_model", {127'd0, done}, {127'd0, m_done});
            chk("text_out_vs_model", text_out, m_out);
        end
    end

    // ---------------- directed stimulus ----------------
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CSP = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PSP = 128'h6bc1bee22e409f96e93d7e117393172a;

    // Waits (bounded) for done, counting falling edges since the ld edge.
    task automatic wait_done(input string name, input int start, input logic [127:0] p);
        int n;
        bit got;
        n   = start;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) got = 1'b1;
        end
        chk({name, "_latency"}, 128'(n), 128'd20);
        chk({name, "_plaintext"}, text_out, p);
    endtask

    // Called just after a falling edge; ld is sampled on the next rising edge.
    task automatic run_vec(input string name, input logic [127:0] k,
                           input logic [127:0] c, input logic [127:0] p);
        key     = k;
        text_in = c;
        ld      = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_done(name, 0, p);
    endtask

    task automatic count_extra_done(input string name);
        int extra;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk(name, 128'(extra), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] rk_, rp_, rc_;
        rst     = 1'b1;
        ld      = 1'b0;
        key     = '0;
        text_in = '0;
        build_sboxes();
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        checking = 1'b1;
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_text_out", text_out, 128'd0);

        // Pin the reference model to published vectors.
        chk("model_dec_c1", ref_dec(K1, C1), P1);
        chk("model_dec_appb", ref_dec(K2, CB), PB);
        chk("model_enc_c1", ref_enc(K1, P1), C1);
        chk("model_dec_sp800", ref_dec(K2, CSP), PSP);

        run_vec("fips_c1", K1, C1, P1);
        count_extra_done("c1_single_done");
        run_vec("fips_appb", K2, CB, PB);
        run_vec("sp800_ecb1", K2, CSP, PSP);
        // ld raised in the done cycle.
        run_vec("c1_in_done_cycle", K1, C1, P1);

        // ld while busy (sampled at E+5) must be ignored.
        @(negedge clk);
        key = K2; text_in = CB; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        repeat (4) @(negedge clk);
        key = K1; text_in = C1; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_done("busy_ld", 5, PB);
        count_extra_done("busy_ld_no_second_done");

        // Reset sampled at E+13 aborts the block.
        key = K1; text_in = C1; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", {127'd0, done}, 128'd0);
        chk("abort_text_out", text_out, 128'd0);
        count_extra_done("abort_no_done");
        run_vec("after_abort", K2, CB, PB);

        // Round trip through the reference encryptor.
        for (int i = 0; i < 4; i++) begin
            rk_ = {$urandom, $urandom, $urandom, $urandom};
            rp_ = {$urandom, $urandom, $urandom, $urandom};
            rc_ = ref_enc(rk_, rp_);
            run_vec($sformatf("roundtrip%0d", i), rk_, rc_, rp_);
        end

        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
